// File: rtl/ahb_sram_slv_if_p.sv
// AHB-Lite slave front-end for a banked single-port synchronous SRAM.
// Writes are pipelined into the data phase; a read landing on a write data phase costs one wait.
module ahb_sram_slv_if_p #(
  parameter int unsigned DW      = 32,
  parameter int unsigned NBANK   = 2,
  parameter int unsigned BANK_AW = 13
) (
  input  logic                    hclk,
  input  logic                    hrst_n,
  input  logic                    hsel,
  input  logic                    hready,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hburst,
  input  logic [2:0]              hsize,
  input  logic                    hwrite,
  input  logic [31:0]             haddr,
  input  logic [DW-1:0]           hwdata,
  output logic [DW-1:0]           hrdata,
  output logic                    hready_out,
  output logic [1:0]              hresp,
  output logic [BANK_AW-1:0]      sram_addr,
  output logic [DW-1:0]           sram_wdata,
  output logic                    sram_wen,
  output logic [NBANK*DW/8-1:0]   sram_csn,
  input  logic [NBANK*DW-1:0]     sram_rdata
);

  localparam int unsigned NL  = DW / 8;
  localparam int unsigned OB  = $clog2(NL);
  localparam int unsigned BB  = (NBANK > 1) ? $clog2(NBANK) : 0;
  localparam int unsigned BBW = (BB > 0) ? BB : 1;

  typedef enum logic [2:0] {StIdle, StWrData, StRdPend, StErr1, StErr2} state_e;

  state_e             state_q, state_d;
  logic               rd_valid_q, rd_valid_d;
  logic [BANK_AW-1:0] addr_q, addr_d;
  logic [BBW-1:0]     bank_q, bank_d;
  logic [NL-1:0]      mask_q, mask_d;

  logic               xfer;
  logic               a_illegal;
  logic [31:0]        a_off;
  logic [BANK_AW-1:0] a_addr;
  logic [BBW-1:0]     a_bank;
  logic [NL-1:0]      a_mask;
  logic               rd_now;
  logic [NL-1:0]      csn_mask;
  logic [BBW-1:0]     csn_bank;

  // Burst type and upper address bits are deliberately ignored (per-beat decode, aliasing).
  logic unused_in;
  assign unused_in = ^{hburst, htrans[0], haddr};

  assign xfer   = hsel & hready & htrans[1];
  assign a_addr = haddr[OB +: BANK_AW];
  assign a_off  = 32'(haddr[OB-1:0]);

  if (NBANK > 1) begin : g_bank
    assign a_bank = haddr[OB+BANK_AW +: BBW];
  end else begin : g_nobank
    assign a_bank = '0;
  end

  always_comb begin
    a_illegal = 32'(hsize) > OB;
    a_mask    = '0;
    for (int unsigned i = 0; i < OB; i++) begin
      if (haddr[i] && (i < 32'(hsize))) a_illegal = 1'b1;
    end
    for (int unsigned i = 0; i < NL; i++) begin
      if (32'(hsize) >= OB) begin
        a_mask[i] = 1'b1;
      end else if ((i >= a_off) && (i < a_off + (32'd1 << hsize))) begin
        a_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = StIdle;
    rd_valid_d = 1'b0;
    addr_d     = addr_q;
    bank_d     = bank_q;
    mask_d     = mask_q;
    rd_now     = 1'b0;
    case (state_q)
      StErr1:   state_d = StErr2;
      StRdPend: rd_valid_d = 1'b1;
      default: begin
        if (xfer) begin
          if (a_illegal) begin
            state_d = StErr1;
          end else begin
            addr_d = a_addr;
            bank_d = a_bank;
            mask_d = a_mask;
            if (hwrite) begin
              state_d = StWrData;
            end else if (state_q == StWrData) begin
              // Port is busy with the write data phase; replay the read next cycle.
              state_d = StRdPend;
            end else begin
              rd_now     = 1'b1;
              rd_valid_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q    <= StIdle;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      bank_q     <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      mask_q     <= mask_d;
    end
  end

  always_comb begin
    sram_wen   = 1'b1;
    sram_addr  = a_addr;
    sram_wdata = hwdata;
    csn_mask   = '0;
    csn_bank   = a_bank;
    if (state_q == StWrData) begin
      sram_wen  = 1'b0;
      sram_addr = addr_q;
      csn_mask  = mask_q;
      csn_bank  = bank_q;
    end else if (state_q == StRdPend) begin
      sram_addr = addr_q;
      csn_mask  = mask_q;
      csn_bank  = bank_q;
    end else if (rd_now) begin
      csn_mask  = a_mask;
    end
    sram_csn = '1;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (32'(csn_bank) == b) sram_csn[b*NL +: NL] = ~csn_mask;
    end
  end

  always_comb begin
    hrdata = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (rd_valid_q && (32'(bank_q) == b)) hrdata = sram_rdata[b*DW +: DW];
    end
  end

  assign hready_out = !((state_q == StErr1) || (state_q == StRdPend));
  assign hresp      = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;

endmodule
